branch_resolve: RTL and testbench



---
 rtl/branch_resolve_if.sv | 31 +++
 rtl/branch_resolve.sv | 132 +++++++++++++
 tb/tb_branch_resolve.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_if.sv
// ============================================================================
// Module   : branch_resolve_if
// Brief    : Branch request (execute side) and redirect (fetch side) handshakes
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface branch_resolve_if #(
  parameter int ADDR_W = 8
);
  logic              br_valid;
  logic              br_ready;
  logic [2:0]        br_type;
  logic [1:0]        comp;
  logic [ADDR_W-1:0] br_target;
  logic              redir_valid;
  logic              redir_ready;
  logic [ADDR_W-1:0] redir_pc;

  modport master (
    output br_valid, br_type, comp, br_target, redir_ready,
    input  br_ready, redir_valid, redir_pc
  );

  modport slave (
    input  br_valid, br_type, comp, br_target, redir_ready,
    output br_ready, redir_valid, redir_pc
  );
endinterface

`default_nettype wire

// File: rtl/branch_resolve.sv
// ============================================================================
// Module   : branch_resolve
// Brief    : Resolves hmmm jumps from zero-compare flags, redirects fetch, flushes
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_resolve #(
  parameter int ADDR_W       = 8,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  branch_resolve_if.slave       bus,
  output logic                  flush,
  output logic                  res_valid,
  output logic                  res_taken,
  output logic                  err,
  output logic [CNT_W-1:0]      taken_cnt
);

  localparam int c_FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [c_FC_W-1:0] c_FLUSH_LAST =
      (FLUSH_CYCLES > 0) ? c_FC_W'(FLUSH_CYCLES - 1) : '0;
  localparam bit c_HAS_FLUSH = (FLUSH_CYCLES > 0);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REDIRECT = 2'd1,
    S_FLUSH    = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_redir_pc;
  logic [c_FC_W-1:0]   r_fcnt;
  logic                r_res_valid;
  logic                r_res_taken;
  logic                r_err;
  logic [CNT_W-1:0]    r_cnt;

  logic w_accept;
  logic w_eq;
  logic w_gt;
  logic w_cond;
  logic w_illegal;
  logic w_taken;
  logic w_redir_hs;

  assign w_accept   = bus.br_valid & (r_state == S_IDLE);
  assign w_redir_hs = bus.redir_ready & (r_state == S_REDIRECT);
  assign w_eq       = bus.comp[1];
  assign w_gt       = bus.comp[0];

  always_comb begin
    w_cond = 1'b0;
    case (bus.br_type)
      3'b000:  w_cond = 1'b1;
      3'b001:  w_cond = w_eq;
      3'b010:  w_cond = ~w_eq;
      3'b011:  w_cond = w_gt;
      3'b100:  w_cond = ~w_eq & ~w_gt;
      default: w_cond = 1'b0;
    endcase
    // eq and gt together cannot come from a real comparator: never jump on it
    w_illegal = (bus.comp == 2'b11) || (bus.br_type > 3'b100);
    w_taken   = w_cond & ~w_illegal;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_taken) w_state_nxt = S_REDIRECT;
      end
      S_REDIRECT: begin
        if (bus.redir_ready) w_state_nxt = c_HAS_FLUSH ? S_FLUSH : S_IDLE;
      end
      S_FLUSH: begin
        if (r_fcnt == '0) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_redir_pc  <= '0;
      r_fcnt      <= '0;
      r_res_valid <= 1'b0;
      r_res_taken <= 1'b0;
      r_err       <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_res_valid <= w_accept;
      if (w_accept) begin
        r_res_taken <= w_taken;
        if (w_illegal) r_err <= 1'b1;
        if (w_taken) begin
          r_redir_pc <= bus.br_target;
          if (r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
        end
      end
      if (w_redir_hs) begin
        r_fcnt <= c_FLUSH_LAST;
      end else if (r_state == S_FLUSH && r_fcnt != '0) begin
        r_fcnt <= r_fcnt - c_FC_W'(1);
      end
    end
  end

  assign bus.br_ready    = (r_state == S_IDLE);
  assign bus.redir_valid = (r_state == S_REDIRECT);
  assign bus.redir_pc    = r_redir_pc;
  assign flush           = (r_state == S_FLUSH);
  assign res_valid       = r_res_valid;
  assign res_taken       = r_res_taken;
  assign err             = r_err;
  assign taken_cnt       = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve.sv
// ============================================================================
// Module   : tb_branch_resolve
// Brief    : Random + directed bench for two branch_resolve configurations
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_resolve;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_resolve_if #(.ADDR_W(8)) bus0 ();
  branch_resolve_if #(.ADDR_W(8)) bus1 ();

  logic [1:0]  flush_w, resv_w, rest_w, err_w;
  logic [15:0] cnt0;
  logic [1:0]  cnt1;

  branch_resolve #(.ADDR_W(8), .FLUSH_CYCLES(2), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave),
    .flush(flush_w[0]), .res_valid(resv_w[0]), .res_taken(rest_w[0]),
    .err(err_w[0]), .taken_cnt(cnt0)
  );

  branch_resolve #(.ADDR_W(8), .FLUSH_CYCLES(0), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave),
    .flush(flush_w[1]), .res_valid(resv_w[1]), .res_taken(rest_w[1]),
    .err(err_w[1]), .taken_cnt(cnt1)
  );

  // Reference model: per-instance pending redirect, remaining flush cycles, counters
  int       fc[2]   = '{2, 0};
  int       cmax[2] = '{65535, 3};
  bit       m_pend[2];
  logic [7:0] m_pc[2];
  int       m_fl[2];
  int       m_cnt[2];
  bit       m_err[2];
  bit       m_rv[2];
  bit       m_rt[2];

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pend[i] = 0; m_pc[i] = '0; m_fl[i] = 0; m_cnt[i] = 0;
      m_err[i] = 0; m_rv[i] = 0; m_rt[i] = 0;
    end
  endtask

  function automatic bit ref_legal(input logic [2:0] t, input logic [1:0] c);
    return (c != 2'b11) && (t <= 3'd4);
  endfunction

  function automatic bit ref_taken(input logic [2:0] t, input logic [1:0] c);
    int sgn;
    if (!ref_legal(t, c)) return 0;
    sgn = c[1] ? 0 : (c[0] ? 1 : -1);
    case (t)
      3'd0: return 1;
      3'd1: return sgn == 0;
      3'd2: return sgn != 0;
      3'd3: return sgn > 0;
      3'd4: return sgn < 0;
      default: return 0;
    endcase
  endfunction

  // Applied at each rising edge, using the inputs present before that edge
  task automatic model_step();
    bit rdy, acc, tk;
    for (int i = 0; i < 2; i++) begin
      rdy = !m_pend[i] && (m_fl[i] == 0);
      acc = bus0.br_valid && rdy;
      tk  = ref_taken(bus0.br_type, bus0.comp);
      if (m_pend[i] && bus0.redir_ready) begin
        m_pend[i] = 0;
        m_fl[i]   = fc[i];
      end else if (m_fl[i] > 0) begin
        m_fl[i]--;
      end
      m_rv[i] = acc;
      if (acc) begin
        m_rt[i] = tk;
        if (!ref_legal(bus0.br_type, bus0.comp)) m_err[i] = 1;
        if (tk) begin
          m_pend[i] = 1;
          m_pc[i]   = bus0.br_target;
          if (m_cnt[i] < cmax[i]) m_cnt[i]++;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("br_ready%0d", i), (i == 0) ? bus0.br_ready : bus1.br_ready,
               32'(!m_pend[i] && m_fl[i] == 0));
      check_eq($sformatf("redir_valid%0d", i), (i == 0) ? bus0.redir_valid : bus1.redir_valid,
               32'(m_pend[i]));
      check_eq($sformatf("redir_pc%0d", i), (i == 0) ? bus0.redir_pc : bus1.redir_pc,
               32'(m_pc[i]));
      check_eq($sformatf("flush%0d", i), 32'(flush_w[i]), 32'(m_fl[i] > 0));
      check_eq($sformatf("res_valid%0d", i), 32'(resv_w[i]), 32'(m_rv[i]));
      if (m_rv[i])
        check_eq($sformatf("res_taken%0d", i), 32'(rest_w[i]), 32'(m_rt[i]));
      check_eq($sformatf("err%0d", i), 32'(err_w[i]), 32'(m_err[i]));
      check_eq($sformatf("taken_cnt%0d", i), (i == 0) ? 32'(cnt0) : 32'(cnt1), 32'(m_cnt[i]));
    end
  endtask

  task automatic drive(input bit v, input logic [2:0] t, input logic [1:0] c,
                       input logic [7:0] tgt, input bit rr);
    bus0.br_valid = v; bus0.br_type = t; bus0.comp = c; bus0.br_target = tgt; bus0.redir_ready = rr;
    bus1.br_valid = v; bus1.br_type = t; bus1.comp = c; bus1.br_target = tgt; bus1.redir_ready = rr;
  endtask

  task automatic drive_random();
    logic [2:0] t;
    logic [1:0] c;
    t = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
    c = ($urandom_range(0, 29) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
    drive($urandom_range(0, 3) != 0, t, c, 8'($urandom), $urandom_range(0, 2) != 0);
  endtask

  // One clock: check state, let the edge happen, advance the model, park on falling edge
  task automatic cycle();
    check_all();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic async_reset_check();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("arst_flush%0d", i), 32'(flush_w[i]), 32'd0);
      check_eq($sformatf("arst_err%0d", i), 32'(err_w[i]), 32'd0);
    end
    check_eq("arst_redir_valid0", 32'(bus0.redir_valid), 32'd0);
    check_eq("arst_cnt0", 32'(cnt0), 32'd0);
    check_eq("arst_cnt1", 32'(cnt1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int guard;
    drive(0, 3'd0, 2'd0, 8'd0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // jeqzn, comp=eq, taken to 0x3C with fetch always ready
    drive(1, 3'd1, 2'b10, 8'h3C, 1);
    cycle();
    drive(0, 3'd0, 2'b00, 8'h00, 1);
    repeat (5) cycle();

    // jgtzn on a negative value, three back to back
    drive(1, 3'd3, 2'b00, 8'h55, 1);
    repeat (3) cycle();

    // jltzn taken, fetch stalls while execute keeps offering another branch
    drive(1, 3'd4, 2'b00, 8'hA7, 0);
    cycle();
    drive(1, 3'd0, 2'b00, 8'h11, 0);
    repeat (5) cycle();
    drive(0, 3'd0, 2'b00, 8'h11, 1);
    repeat (4) cycle();

    // illegal comp then reserved type; err must survive later legal branches
    drive(1, 3'd2, 2'b11, 8'h20, 1);
    cycle();
    drive(1, 3'd6, 2'b01, 8'h21, 1);
    cycle();
    drive(1, 3'd3, 2'b01, 8'h22, 1);
    repeat (3) cycle();

    // five unconditional jumps: saturates the 2-bit counter
    for (int k = 0; k < 5; k++) begin
      drive(1, 3'd0, 2'b01, 8'(8'h40 + k), 1);
      cycle();
      drive(0, 3'd0, 2'b01, 8'h00, 1);
      repeat (4) cycle();
    end

    repeat (300) begin
      drive_random();
      cycle();
    end

    // drop reset between edges while the FLUSH_CYCLES=2 instance is flushing
    drive(1, 3'd0, 2'b00, 8'h77, 1);
    guard = 0;
    while (m_fl[0] == 0 && guard < 20) begin
      check_all();
      @(posedge clk);
      model_step();
      if (m_fl[0] == 0) @(negedge clk);
      guard++;
    end
    check_eq("reach_flush", 32'(m_fl[0] > 0), 32'd1);
    async_reset_check();
    cycle();

    repeat (200) begin
      drive_random();
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
